muldiv_unit: RTL

Iterative RV32M multiply/divide unit in the execute stage. It accepts one operation per start pulse, computes it over WIDTH cycles (one bit per cycle), and holds the result. That result is one data input of the 8-input writeback result multiplexer. The core stalls on busy.

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/muldiv_unit_if.sv | 30 +++
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Core-wide shared package (multiply/divide portion).
// Holds the RV32M funct3 encodings used as the MDU operation code, the MDU
// control-state encoding, and small decode helpers shared by the MDU.
package riscv_pkg;

  // funct3 of the RV32M instructions, used directly as the MDU opcode.
  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // rs1 is interpreted as signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_signed_a(mdu_op_e op);
    return (op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM});
  endfunction

  // rs2 is interpreted as signed for MULH, DIV and REM.
  function automatic logic op_signed_b(mdu_op_e op);
    return (op inside {MDU_MULH, MDU_DIV, MDU_REM});
  endfunction

  // Bit 2 of funct3 separates the divide group from the multiply group.
  function automatic logic op_is_div(mdu_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide
// unit.
//   start  : request pulse, honoured only while the unit is not busy
//   op     : RV32M funct3
//   a, b   : rs1 / rs2 operands, sampled with start
//   busy   : unit is iterating (core stalls)
//   done   : one-cycle pulse, result valid
//   result : held until the next accepted request completes
// master = requester (core), slave = the unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// One operation per accepted start; WIDTH iterations (one bit per cycle) of a
// shift-add multiply or restoring divide on operand magnitudes, followed by a
// two's-complement sign fixup. Division by zero and signed overflow skip the
// iterations and complete in the cycle after acceptance.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : muldiv_unit_if slave (start/op/a/b in, busy/done/result out)
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int                 CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ALL_ONES = '1;
  localparam logic [WIDTH-1:0]   MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e         state_q;
  mdu_op_e            op_q;
  logic               sign_a_q;
  logic               sign_b_q;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]   opd_q;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;

  // Acceptance-side decode of the incoming request.
  mdu_op_e          op_in;
  logic             sign_a_in;
  logic             sign_b_in;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic             div_zero_in;
  logic             div_ovf_in;
  logic             special_in;
  logic [WIDTH-1:0] special_res;

  always_comb begin
    op_in       = mdu_op_e'(bus.op);
    sign_a_in   = bus.a[WIDTH-1] & op_signed_a(op_in);
    sign_b_in   = bus.b[WIDTH-1] & op_signed_b(op_in);
    mag_a_in    = sign_a_in ? -bus.a : bus.a;
    mag_b_in    = sign_b_in ? -bus.b : bus.b;
    div_zero_in = op_is_div(op_in) && (bus.b == '0);
    // Only the signed divide ops (DIV, REM) can overflow.
    div_ovf_in  = op_is_div(op_in) && op_signed_a(op_in) &&
                  (bus.a == MIN_NEG) && (bus.b == ALL_ONES);
    special_in  = div_zero_in | div_ovf_in;
    // funct3 bit 1 selects remainder within the divide group.
    if (div_zero_in) begin
      special_res = op_in[1] ? bus.a : ALL_ONES;
    end else begin
      special_res = op_in[1] ? '0 : bus.a;
    end
  end

  // One iteration step and the sign-fixed result it would produce.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   calc_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
    // Trial subtract of the divisor from the remainder shifted left by one
    // dividend bit; the top bit of the difference is the borrow.
    div_diff = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opd_q};

    if (op_is_div(op_q)) begin
      if (!div_diff[WIDTH]) begin
        acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_q[0]) begin
        acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      end else begin
        acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
      end
    end

    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_step : acc_step;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem_fix  = sign_a_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];

    if (op_is_div(op_q)) begin
      calc_res = op_q[1] ? rem_fix : quo_fix;
    end else begin
      calc_res = (op_q == MDU_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MDU_IDLE;
      op_q     <= MDU_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opd_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        MDU_IDLE, MDU_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q     <= op_in;
            sign_a_q <= sign_a_in;
            sign_b_q <= sign_b_in;
            cnt_q    <= '0;
            opd_q    <= op_is_div(op_in) ? mag_b_in : mag_a_in;
            acc_q    <= {{WIDTH{1'b0}}, (op_is_div(op_in) ? mag_a_in : mag_b_in)};
            if (special_in) begin
              state_q  <= MDU_DONE;
              done_q   <= 1'b1;
              result_q <= special_res;
            end else begin
              state_q <= MDU_CALC;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= MDU_IDLE;
          end
        end
        MDU_CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
          // This edge performs the final iteration: capture its fixed result.
          if (cnt_q == CNT_LAST) begin
            state_q  <= MDU_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= calc_res;
          end
        end
        default: begin
          state_q <= MDU_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
